core_mem_arb: RTL



---
 rtl/core_arb_pkg.sv | 17 +
 rtl/core_nc_check.sv | 14 +
 rtl/core_mem_arb.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/core_arb_pkg.sv
// rtl/core_arb_pkg.sv - arbiter state type and downstream opcode/size encodings
package core_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  localparam logic [2:0] COP_RD    = 3'd0;
  localparam logic [2:0] COP_WR    = 3'd1;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

endpackage

// File: rtl/core_nc_check.sv
// rtl/core_nc_check.sv - non-cacheable region match on base/mask, shared with the pipeline
module core_nc_check #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] mask,
  output logic                  hit
);

  // Mask bits mark the offset within the region; the rest must equal the base.
  assign hit = ((addr & ~mask) == base);

endmodule

// File: rtl/core_mem_arb.sv
// rtl/core_mem_arb.sv - instruction/data arbiter onto a single downstream memory port
// CORE_ARB_RR_EN selects round-robin tie-breaking; otherwise data has fixed priority.
module core_mem_arb
  import core_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_val,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  output logic                  i_req_ack,
  output logic [DATA_WIDTH-1:0] i_ack_rdata,
  input  logic                  d_req_val,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [2:0]            d_req_cop,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  input  logic [2:0]            d_req_size,
  output logic                  d_req_ack,
  output logic [DATA_WIDTH-1:0] d_ack_rdata,
  input  logic [ADDR_WIDTH-1:0] ncache_base,
  input  logic [ADDR_WIDTH-1:0] ncache_mask,
  output logic                  m_req_val,
  output logic [ADDR_WIDTH-1:0] m_req_addr,
  output logic [2:0]            m_req_cop,
  output logic [DATA_WIDTH-1:0] m_req_wdata,
  output logic [2:0]            m_req_size,
  output logic                  m_req_nc,
  input  logic                  m_req_ack,
  input  logic [DATA_WIDTH-1:0] m_ack_rdata
);

  arb_state_t state_q, state_d;
  logic       pick_d;
  logic       nc_hit;

`ifdef CORE_ARB_RR_EN
  // 1 = data was granted last; resets to instruction so data wins the first tie.
  logic       last_gnt_q, last_gnt_d;
`endif

  always_comb begin
    state_d = state_q;
    pick_d  = d_req_val;
`ifdef CORE_ARB_RR_EN
    last_gnt_d = last_gnt_q;
    if (i_req_val && d_req_val) pick_d = ~last_gnt_q;
`else
    if (i_req_val && d_req_val) pick_d = 1'b1;
`endif
    case (state_q)
      IDLE: begin
        if (i_req_val || d_req_val) state_d = pick_d ? GNT_D : GNT_I;
      end
      GNT_I: begin
        if (m_req_ack) begin
          state_d = IDLE;
`ifdef CORE_ARB_RR_EN
          last_gnt_d = 1'b0;
`endif
        end
      end
      GNT_D: begin
        if (m_req_ack) begin
          state_d = IDLE;
`ifdef CORE_ARB_RR_EN
          last_gnt_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
`ifdef CORE_ARB_RR_EN
      last_gnt_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef CORE_ARB_RR_EN
      last_gnt_q <= last_gnt_d;
`endif
    end
  end

  // Downstream request and the ack return path follow the grant combinationally.
  always_comb begin
    m_req_val   = 1'b0;
    m_req_addr  = '0;
    m_req_cop   = '0;
    m_req_wdata = '0;
    m_req_size  = '0;
    i_req_ack   = 1'b0;
    i_ack_rdata = '0;
    d_req_ack   = 1'b0;
    d_ack_rdata = '0;
    case (state_q)
      GNT_I: begin
        m_req_val   = i_req_val;
        m_req_addr  = i_req_addr;
        m_req_cop   = COP_RD;
        m_req_size  = SIZE_WORD;
        i_req_ack   = m_req_ack;
        i_ack_rdata = m_req_ack ? m_ack_rdata : '0;
      end
      GNT_D: begin
        m_req_val   = d_req_val;
        m_req_addr  = d_req_addr;
        m_req_cop   = d_req_cop;
        m_req_wdata = d_req_wdata;
        m_req_size  = d_req_size;
        d_req_ack   = m_req_ack;
        d_ack_rdata = m_req_ack ? m_ack_rdata : '0;
      end
      default: ;
    endcase
  end

  core_nc_check #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_nc_check (
    .addr(m_req_addr),
    .base(ncache_base),
    .mask(ncache_mask),
    .hit (nc_hit)
  );

  // The tag is only meaningful while a request is presented; idle outputs stay at zero.
  assign m_req_nc = nc_hit && (state_q != IDLE);

  a_i_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == GNT_I) |-> i_req_val);
  a_d_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == GNT_D) |-> d_req_val);
  a_no_idle_ack: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == IDLE) |-> !m_req_ack);

endmodule
